// File: rtl/mem_stage_if.sv
// EX -> MEM -> WB handshake and payload bundle for the MEM stage.
// The slave modport is the MEM stage itself; the master modport is its
// surroundings (EX stage, data SRAM, WB stage and the flush source).
interface mem_stage_if;
    logic        flush;

    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_res;
    logic [1:0]  es_offset;
    logic [4:0]  es_load_type;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic        es_ex;
    logic        es_adel;

    logic [31:0] data_ram_rdata;

    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_res;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic        ms_ex;
    logic [31:0] ms_badvaddr;

    logic        ms_fwd_we;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;

    modport slave (
        input  flush,
        input  es_to_ms_valid,
        output ms_allowin,
        input  es_pc,
        input  es_res,
        input  es_offset,
        input  es_load_type,
        input  es_gr_we,
        input  es_dest,
        input  es_ex,
        input  es_adel,
        input  data_ram_rdata,
        input  ws_allowin,
        output ms_to_ws_valid,
        output ms_pc,
        output ms_final_res,
        output ms_gr_we,
        output ms_dest,
        output ms_ex,
        output ms_badvaddr,
        output ms_fwd_we,
        output ms_fwd_dest,
        output ms_fwd_data
    );

    modport master (
        output flush,
        output es_to_ms_valid,
        input  ms_allowin,
        output es_pc,
        output es_res,
        output es_offset,
        output es_load_type,
        output es_gr_we,
        output es_dest,
        output es_ex,
        output es_adel,
        output data_ram_rdata,
        output ws_allowin,
        input  ms_to_ws_valid,
        input  ms_pc,
        input  ms_final_res,
        input  ms_gr_we,
        input  ms_dest,
        input  ms_ex,
        input  ms_badvaddr,
        input  ms_fwd_we,
        input  ms_fwd_dest,
        input  ms_fwd_data
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage of the 32-bit MIPS datapath.
// Registers the EX payload, holds synchronous SRAM read data across WB
// stalls, extracts/extends load data and exposes a bypass tap for decode.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    logic        ms_valid;
    logic        ms_ready_go;
    logic        accept;

    logic [31:0] pc;
    logic [31:0] res;
    logic [1:0]  offset;
    logic [4:0]  load_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic        ex;
    logic        adel;

    logic        rbuf_valid;
    logic [31:0] rbuf;
    logic [31:0] rdata;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] final_res;
    logic        ex_any;
    logic        gr_we_eff;

    // The stage never needs more than one cycle; the SRAM answers in time.
    assign ms_ready_go = 1'b1;
    assign bus.ms_allowin     = !ms_valid || (ms_ready_go && bus.ws_allowin);
    assign bus.ms_to_ws_valid = ms_valid && ms_ready_go && !bus.flush;
    assign accept = bus.es_to_ms_valid && bus.ms_allowin && !bus.flush;

    // Stage valid bit: flush kills whatever is in MEM or arriving into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (bus.flush) begin
            ms_valid <= 1'b0;
        end else if (bus.ms_allowin) begin
            ms_valid <= bus.es_to_ms_valid;
        end
    end

    // Payload registers load only when a live instruction is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= 32'h0;
            res       <= 32'h0;
            offset    <= 2'b00;
            load_type <= 5'b00000;
            gr_we     <= 1'b0;
            dest      <= 5'd0;
            ex        <= 1'b0;
            adel      <= 1'b0;
        end else if (accept) begin
            pc        <= bus.es_pc;
            res       <= bus.es_res;
            offset    <= bus.es_offset;
            load_type <= bus.es_load_type;
            gr_we     <= bus.es_gr_we;
            dest      <= bus.es_dest;
            ex        <= bus.es_ex;
            adel      <= bus.es_adel;
        end
    end

    // SRAM data is only present in the first MEM cycle; keep a copy while
    // WB stalls. rbuf_valid doubles as the "not first cycle" flag, so a
    // stalled instruction captures exactly once.
    always_ff @(posedge clk) begin
        if (reset) begin
            rbuf_valid <= 1'b0;
            rbuf       <= 32'h0;
        end else if (bus.flush || (bus.ms_to_ws_valid && bus.ws_allowin)) begin
            rbuf_valid <= 1'b0;
        end else if (ms_valid && !bus.ws_allowin && !rbuf_valid) begin
            rbuf_valid <= 1'b1;
            rbuf       <= bus.data_ram_rdata;
        end
    end

    assign rdata = rbuf_valid ? rbuf : bus.data_ram_rdata;

    // Lane select and sign/zero extension of the load result.
    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        final_res = res;
        if (load_type[0]) begin
            final_res = rdata;
        end else if (load_type[1]) begin
            final_res = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_type[2]) begin
            final_res = {24'h0, byte_sel};
        end else if (load_type[3]) begin
            final_res = {{16{half_sel[15]}}, half_sel};
        end else if (load_type[4]) begin
            final_res = {16'h0, half_sel};
        end
    end

    // A faulting instruction must never reach the register file.
    assign ex_any    = ex || adel;
    assign gr_we_eff = gr_we && !ex_any;

    assign bus.ms_pc        = pc;
    assign bus.ms_final_res = final_res;
    assign bus.ms_gr_we     = gr_we_eff;
    assign bus.ms_dest      = dest;
    assign bus.ms_ex        = ex_any;
    assign bus.ms_badvaddr  = res;

    assign bus.ms_fwd_we    = ms_valid && gr_we_eff;
    assign bus.ms_fwd_dest  = dest;
    assign bus.ms_fwd_data  = final_res;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extraction, passthrough, WB stall
// buffering, address-error handling, flush and reset interactions.
module tb_mem_stage;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    mem_stage_if bus ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from EX for a single cycle.
    task automatic issue(input logic [31:0] pc, input logic [4:0] lt, input logic [1:0] off,
                         input logic [31:0] res, input logic gwe, input logic [4:0] dst,
                         input logic exc, input logic adl);
        bus.es_pc          = pc;
        bus.es_load_type   = lt;
        bus.es_offset      = off;
        bus.es_res         = res;
        bus.es_gr_we       = gwe;
        bus.es_dest        = dst;
        bus.es_ex          = exc;
        bus.es_adel        = adl;
        bus.es_to_ms_valid = 1'b1;
        tick();
        bus.es_to_ms_valid = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  lt;
        logic [1:0]  off;
        logic [31:0] exp;
        string       tag;
    } ld_vec_t;

    ld_vec_t ld_vecs[6];

    initial begin
        n_chk = 0;
        n_err = 0;
        ld_vecs[0] = '{5'b00010, 2'd0, 32'hFFFF_FF82, "lb_off0"};
        ld_vecs[1] = '{5'b00100, 2'd0, 32'h0000_0082, "lbu_off0"};
        ld_vecs[2] = '{5'b00010, 2'd1, 32'h0000_007F, "lb_off1"};
        ld_vecs[3] = '{5'b01000, 2'd2, 32'hFFFF_80F1, "lh_off2"};
        ld_vecs[4] = '{5'b10000, 2'd2, 32'h0000_80F1, "lhu_off2"};
        ld_vecs[5] = '{5'b00001, 2'd0, 32'h80F1_7F82, "lw"};

        reset = 1'b1;
        bus.flush = 1'b0;
        bus.es_to_ms_valid = 1'b0;
        bus.es_pc = 32'h0;
        bus.es_res = 32'h0;
        bus.es_offset = 2'b00;
        bus.es_load_type = 5'b0;
        bus.es_gr_we = 1'b0;
        bus.es_dest = 5'd0;
        bus.es_ex = 1'b0;
        bus.es_adel = 1'b0;
        bus.data_ram_rdata = 32'h0;
        bus.ws_allowin = 1'b1;

        tick();
        tick();
        chk("rst_allowin",  32'(bus.ms_allowin), 32'd1);
        chk("rst_to_ws",    32'(bus.ms_to_ws_valid), 32'd0);
        chk("rst_fwd_we",   32'(bus.ms_fwd_we), 32'd0);
        chk("rst_final",    bus.ms_final_res, 32'h0);
        chk("rst_pc",       bus.ms_pc, 32'h0);
        chk("rst_badvaddr", bus.ms_badvaddr, 32'h0);
        reset = 1'b0;
        tick();

        // Load extraction, one instruction at a time, WB always ready.
        for (int i = 0; i < 6; i++) begin
            issue(32'h0000_1000 + 32'(i * 4), ld_vecs[i].lt, ld_vecs[i].off,
                  32'h0000_2000, 1'b1, 5'd3, 1'b0, 1'b0);
            bus.data_ram_rdata = 32'h80F1_7F82;
            #1;
            chk(ld_vecs[i].tag, bus.ms_final_res, ld_vecs[i].exp);
            chk({ld_vecs[i].tag, "_v"}, 32'(bus.ms_to_ws_valid), 32'd1);
            chk({ld_vecs[i].tag, "_fwd"}, bus.ms_fwd_data, ld_vecs[i].exp);
            tick();
            bus.data_ram_rdata = 32'h0;
        end

        // Non-load passthrough.
        issue(32'h0000_1100, 5'b0, 2'd0, 32'h1234_5678, 1'b1, 5'd7, 1'b0, 1'b0);
        #1;
        chk("alu_res",      bus.ms_final_res, 32'h1234_5678);
        chk("alu_gr_we",    32'(bus.ms_gr_we), 32'd1);
        chk("alu_fwd_we",   32'(bus.ms_fwd_we), 32'd1);
        chk("alu_fwd_dest", 32'(bus.ms_fwd_dest), 32'd7);
        tick();

        // Back-to-back loads, WB ready, one per cycle.
        bus.es_pc = 32'h0000_1200; bus.es_load_type = 5'b00010; bus.es_offset = 2'd0;
        bus.es_res = 32'h0; bus.es_gr_we = 1'b1; bus.es_dest = 5'd4;
        bus.es_to_ms_valid = 1'b1;
        tick();
        bus.es_pc = 32'h0000_1204; bus.es_load_type = 5'b00100;
        bus.data_ram_rdata = 32'h0000_00FF;
        #1;
        chk("b2b_first",  bus.ms_final_res, 32'hFFFF_FFFF);
        tick();
        bus.es_to_ms_valid = 1'b0;
        bus.data_ram_rdata = 32'h0000_0080;
        #1;
        chk("b2b_second", bus.ms_final_res, 32'h0000_0080);
        chk("b2b_pc",     bus.ms_pc, 32'h0000_1204);
        tick();

        // WB stall for three cycles: rdata must be held from the first cycle.
        bus.ws_allowin = 1'b0;
        issue(32'h0000_1300, 5'b00001, 2'd0, 32'h0000_3000, 1'b1, 5'd9, 1'b0, 1'b0);
        bus.data_ram_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_res",     bus.ms_final_res, 32'hDEAD_BEEF);
            chk("stall_allowin", 32'(bus.ms_allowin), 32'd0);
            tick();
            bus.data_ram_rdata = 32'h0;
        end
        bus.ws_allowin = 1'b1;
        #1;
        chk("handoff_v",       32'(bus.ms_to_ws_valid), 32'd1);
        chk("handoff_res",     bus.ms_final_res, 32'hDEAD_BEEF);
        chk("handoff_allowin", 32'(bus.ms_allowin), 32'd1);
        tick();
        chk("after_handoff_v", 32'(bus.ms_to_ws_valid), 32'd0);
        chk("after_rbuf",      32'(dut.rbuf_valid), 32'd0);

        // Load address error.
        issue(32'h0000_1400, 5'b00001, 2'd1, 32'h0000_1001, 1'b1, 5'd10, 1'b0, 1'b1);
        #1;
        chk("adel_ex",       32'(bus.ms_ex), 32'd1);
        chk("adel_gr_we",    32'(bus.ms_gr_we), 32'd0);
        chk("adel_badvaddr", bus.ms_badvaddr, 32'h0000_1001);
        chk("adel_fwd_we",   32'(bus.ms_fwd_we), 32'd0);
        tick();

        // Flush in the same cycle as an incoming instruction.
        bus.flush = 1'b1;
        issue(32'h0000_1500, 5'b00001, 2'd0, 32'h0000_5000, 1'b1, 5'd11, 1'b0, 1'b0);
        bus.flush = 1'b0;
        #1;
        chk("flush_in_v",       32'(bus.ms_to_ws_valid), 32'd0);
        chk("flush_in_fwd_we",  32'(bus.ms_fwd_we), 32'd0);
        chk("flush_in_allowin", 32'(bus.ms_allowin), 32'd1);
        chk("flush_in_pc_hold", bus.ms_pc, 32'h0000_1400);

        // Flush while a stalled load holds the read buffer.
        bus.ws_allowin = 1'b0;
        issue(32'h0000_1600, 5'b00001, 2'd0, 32'h0000_6000, 1'b1, 5'd12, 1'b0, 1'b0);
        bus.data_ram_rdata = 32'hAAAA_5555;
        tick();
        bus.data_ram_rdata = 32'h0;
        #1;
        chk("fstall_held", bus.ms_final_res, 32'hAAAA_5555);
        bus.flush = 1'b1;
        #1;
        chk("fstall_v_flush", 32'(bus.ms_to_ws_valid), 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fstall_v",    32'(bus.ms_to_ws_valid), 32'd0);
        chk("fstall_rbuf", 32'(dut.rbuf_valid), 32'd0);
        issue(32'h0000_1700, 5'b00001, 2'd0, 32'h0000_7000, 1'b1, 5'd13, 1'b0, 1'b0);
        bus.data_ram_rdata = 32'h1357_9BDF;
        #1;
        chk("fresh_res", bus.ms_final_res, 32'h1357_9BDF);
        tick();
        bus.ws_allowin = 1'b1;
        tick();

        // Reset in the middle of a stall.
        bus.ws_allowin = 1'b0;
        issue(32'h0000_1800, 5'b00001, 2'd0, 32'h0000_8000, 1'b1, 5'd14, 1'b1, 1'b0);
        bus.data_ram_rdata = 32'h0BAD_F00D;
        tick();
        bus.data_ram_rdata = 32'h0000_0055;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstm_allowin",  32'(bus.ms_allowin), 32'd1);
        chk("rstm_to_ws",    32'(bus.ms_to_ws_valid), 32'd0);
        chk("rstm_fwd_we",   32'(bus.ms_fwd_we), 32'd0);
        chk("rstm_final",    bus.ms_final_res, 32'h0);
        chk("rstm_pc",       bus.ms_pc, 32'h0);
        chk("rstm_dest",     32'(bus.ms_dest), 32'd0);
        chk("rstm_ex",       32'(bus.ms_ex), 32'd0);
        chk("rstm_badvaddr", bus.ms_badvaddr, 32'h0);
        chk("rstm_rbuf",     32'(dut.rbuf_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage directly downstream of the execute-stage ALU.
- Registers the ALU result, byte offset, load type and exception flags on a valid/allowin handshake.
- Captures synchronous data-RAM read data, which returns one cycle after the address is issued from EX.
- Performs load byte/halfword extraction and extension, then hands the result to WB.
- Provides a forwarding tap for the decode-stage bypass network.

Parameters:
- None. Widths are fixed by the 32-bit MIPS datapath.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  exception/eret flush from WB; kills the MEM-stage instruction
es_to_ms_valid  in  1  EX stage presents a valid instruction
ms_allowin  out  1  MEM stage can accept this cycle
es_pc  in  32  instruction PC
es_res  in  32  ALU result (address for loads/stores)
es_offset  in  2  low address bits from ALU
es_load_type  in  5  one-hot: [0] lw, [1] lb, [2] lbu, [3] lh, [4] lhu; 0 = not a load
es_gr_we  in  1  instruction writes GPR
es_dest  in  5  destination GPR
es_ex  in  1  exception already raised upstream (incl. overflow, ades)
es_adel  in  1  load address error
data_ram_rdata  in  32  SRAM read data, valid the cycle after the address was issued
ws_allowin  in  1  WB stage can accept
ms_to_ws_valid  out  1  MEM stage presents a valid instruction to WB
ms_pc  out  32  registered PC
ms_final_res  out  32  load data or passthrough ALU result
ms_gr_we  out  1  GPR write enable to WB
ms_dest  out  5  destination GPR
ms_ex  out  1  exception flag (es_ex | es_adel)
ms_badvaddr  out  32  faulting address, equal to the registered es_res
ms_fwd_we  out  1  forwarding valid: ms_valid & ms_gr_we
ms_fwd_dest  out  5  forwarding destination
ms_fwd_data  out  32  forwarding data, equal to ms_final_res

Behaviour:
- Stage valid and handshake
  - ms_valid register: reset -> 0; else flush -> 0; else if ms_allowin -> es_to_ms_valid.
  - ms_ready_go = 1.
  - ms_allowin = !ms_valid | ws_allowin.
  - ms_to_ws_valid = ms_valid & !flush.
- Payload registers
  - pc, res, offset, load_type, gr_we, dest, ex, adel load only when es_to_ms_valid & ms_allowin & !flush.
  - Otherwise they hold their value.
  - Reset value of all payload registers is 0.
- Read-data buffer (WB stall hazard)
  - SRAM data is valid only in the first cycle an instruction sits in MEM.
  - rbuf_valid sets, and rbuf <= data_ram_rdata, when ms_valid & !ws_allowin & !rbuf_valid.
  - rbuf_valid clears when the instruction leaves (ms_to_ws_valid & ws_allowin), on flush, or on reset.
  - Effective rdata = rbuf_valid ? rbuf : data_ram_rdata.
  - The first-cycle flag is rbuf_valid itself, so at most one capture per instruction.
- Load extraction
  - Byte is rdata[8*offset+7 : 8*offset].
  - Half is rdata[31:16] if offset[1], else rdata[15:0].
  - lw: rdata. lb: sign-extended byte. lbu: zero-extended byte. lh: sign-extended half. lhu: zero-extended half.
  - load_type == 0: ms_final_res = registered res.
- Exceptions
  - ms_ex = ex | adel.
  - ms_gr_we = gr_we & !ms_ex, so a faulting load never writes the GPR.
  - ms_badvaddr = res.
  - ms_final_res is don't-care when ms_ex.
- Outputs
  - All outputs are combinational from the registers above.
  - Reset state: ms_allowin = 1, ms_to_ws_valid = 0, ms_fwd_we = 0, all data outputs 0.
- Simultaneous events
  - flush and es_to_ms_valid in the same cycle: flush wins, ms_valid = 0 next cycle.
  - flush and ws_allowin in the same cycle: nothing is handed to WB.
  - Back-to-back loads with ws_allowin = 1: one instruction per cycle, rbuf unused.

Test Plan:
- lb/lbu/lh/lhu/lw with rdata 0x80F1_7F82:
  - lb offset 0 -> 0xFFFF_FF82; lbu offset 0 -> 0x0000_0082.
  - lb offset 1 -> 0x0000_007F.
  - lh offset 2 -> 0xFFFF_80F1; lhu offset 2 -> 0x0000_80F1.
  - lw -> 0x80F1_7F82.
- Non-load with es_res = 0x1234_5678 and load_type 0 -> ms_final_res = 0x1234_5678, ms_gr_we = 1 after one cycle.
- WB stall: lw enters, rdata 0xDEAD_BEEF in the first MEM cycle, then 0x0; ws_allowin low for 3 cycles.
  - Required: ms_final_res stays 0xDEAD_BEEF, ms_allowin = 0 throughout the stall.
  - Required: handoff occurs on the cycle ws_allowin returns high.
- Load with es_adel = 1, es_res = 0x0000_1001, es_gr_we = 1 -> ms_ex = 1, ms_gr_we = 0, ms_badvaddr = 0x0000_1001, ms_fwd_we = 0.
- flush asserted in the same cycle as es_to_ms_valid, and again while a stalled load holds rbuf.
  - Required: ms_to_ws_valid = 0 next cycle, rbuf_valid = 0.
  - Required: the next load takes fresh SRAM data.
- reset asserted mid-stall -> next cycle ms_valid = 0, ms_allowin = 1, all outputs 0.
